mips_cpu_muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the Harvard CPU. Owns the architectural HI/LO registers, so the single-cycle ALU keeps only the one-cycle ops.
- Runs radix-2 shift-add multiply and restoring divide, one iteration per clock, then applies sign correction.
- Drives an interlock (stall) so the pipeline holds any MULT/DIV/MTHI/MTLO/MFHI/MFLO issued while an operation is in flight.

---
 rtl/mips_cpu_muldiv_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mips_cpu_muldiv_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// mips_cpu_muldiv_ctrl : multi-cycle MULT/DIV sequencer owning HI/LO + stall
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_cpu_muldiv_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  mf_req,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic [W-1:0]         acc_hi_q, acc_hi_d;
  logic [W-1:0]         acc_lo_q, acc_lo_d;
  logic [W-1:0]         opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [W-1:0]         a_mag, b_mag;
  logic                 b_zero;
  logic [W:0]           mul_sum;
  logic [W:0]           div_shift;
  logic [W+1:0]         div_diff;
  logic [2*W-1:0]       product;

  always_comb begin
    a_mag     = (op[0] & a[W-1]) ? (-a) : a;
    b_mag     = (op[0] & b[W-1]) ? (-b) : b;
    b_zero    = (b == '0);
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    product   = {acc_hi_q, acc_lo_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001: begin
              state_d   = ST_MUL;
              acc_hi_d  = '0;
              acc_lo_d  = b_mag;
              opnd_d    = a_mag;
              cnt_d     = '0;
              busy_d    = 1'b1;
              is_div_d  = 1'b0;
              neg_res_d = op[0] & (a[W-1] ^ b[W-1]);
              neg_rem_d = 1'b0;
            end
            3'b010, 3'b011: begin
              state_d   = ST_DIV;
              acc_hi_d  = '0;
              acc_lo_d  = a_mag;
              opnd_d    = b_mag;
              cnt_d     = '0;
              busy_d    = 1'b1;
              is_div_d  = 1'b1;
              // Divide-by-zero keeps the all-ones quotient; the remainder
              // (|a| re-signed by a's sign) then equals the raw a.
              neg_res_d = op[0] & (a[W-1] ^ b[W-1]) & ~b_zero;
              neg_rem_d = op[0] & a[W-1];
            end
            3'b100:  hi_d = a;
            3'b101:  lo_d = a;
            default: ;
          endcase
        end
      end

      ST_MUL: begin
        acc_hi_d = mul_sum[W:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
        cnt_d    = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_ITER) state_d = ST_FIX;
      end

      ST_DIV: begin
        if (!div_diff[W+1]) begin
          acc_hi_d = div_diff[W-1:0];
          acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
        end else begin
          acc_hi_d = div_shift[W-1:0];
          acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_ITER) state_d = ST_FIX;
      end

      ST_FIX: begin
        if (is_div_q) begin
          lo_d = neg_res_q ? (-acc_lo_q) : acc_lo_q;
          hi_d = neg_rem_q ? (-acc_hi_q) : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? (-product) : product;
        end
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q & (start | mf_req);

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_muldiv_ctrl : scoreboard bench for the MULT/DIV sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mips_cpu_muldiv_ctrl;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        mf_req  = 1'b0;
  logic [2:0]  op      = 3'd0;
  logic [31:0] a       = 32'd0;
  logic [31:0] b       = 32'd0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  mips_cpu_muldiv_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk    (clk),
    .reset  (reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .mf_req (mf_req),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse retires one expected HI/LO pair.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_hi", hi, mon_e.hi);
        check("sb_lo", lo, mon_e.lo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
  endtask

  // Called at a negedge with the request driven; returns at the done-cycle negedge.
  task automatic wait_done(output int nbusy, output bit got);
    nbusy = 0;
    got   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
    int n;
    bit got;
    push_exp(eh, el);
    issue(o, av, bv);
    wait_done(n, got);
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_busy_cycles"}, 32'(n), 32'd33);
    check({name, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int miss;

    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    mf_req = 1'b1;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    mf_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run("mult_neg3x5", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    run("multu_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("div_neg7by2", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_by0", 3'b010, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run("div_neg_by0", 3'b011, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run("mult_negneg", 3'b001, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'd0, 32'd20);
    @(negedge clk);

    // MULT 6*7 with MTHI and MFxx held against the interlock.
    push_exp(32'd0, 32'd42);
    issue(3'b001, 32'd6, 32'd7);
    @(posedge clk);
    #1;
    op     = 3'b100;
    a      = 32'h0000_1234;
    b      = 32'd0;
    mf_req = 1'b1;
    n      = 0;
    miss   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) break;
      if (!stall) miss++;
      n++;
    end
    check("hold_stall_missed", 32'(miss), 32'd0);
    check("hold_busy_cycles", 32'(n), 32'd33);
    check("hold_stall_in_done", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    start  = 1'b0;
    mf_req = 1'b0;
    @(negedge clk);
    check("held_mthi_hi", hi, 32'h0000_1234);
    check("held_mthi_lo", lo, 32'd42);
    check("held_mthi_busy", 32'(busy), 32'd0);

    // Reset aborts an in-flight divide.
    issue(3'b100, 32'h0000_AAAA, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("mthi_hi", hi, 32'h0000_AAAA);
    check("mthi_lo_kept", lo, 32'd42);
    issue(3'b010, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_busy_later", 32'(busy), 32'd0);
    run("divu_100by7", 3'b010, 32'd100, 32'd7, 32'd2, 32'd14);

    // Inputs without start, and reserved opcodes, leave HI/LO alone.
    op = 3'b101;
    a  = 32'h0000_DEAD;
    repeat (3) @(negedge clk);
    check("nostart_hi", hi, 32'd2);
    check("nostart_lo", lo, 32'd14);
    issue(3'b110, 32'h5555_5555, 32'd1);
    mf_req = 1'b1;
    #1;
    check("op110_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("op110_busy", 32'(busy), 32'd0);
    check("op110_hi", hi, 32'd2);
    check("op110_lo", lo, 32'd14);
    mf_req = 1'b0;
    issue(3'b101, 32'h0000_BEEF, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("mtlo_lo", lo, 32'h0000_BEEF);
    check("mtlo_hi_kept", hi, 32'd2);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
